// File: rtl/shift_exec_stage.sv
// shift_exec_stage
//   Execute-stage wrapper around a combinational barrel shifter for the RV32I
//   shift ops (SLL/SRL/SRA and their immediate forms). Two register stages:
//   stage 1 holds the decoded operands, stage 2 holds the shifted result and
//   its destination tag. Both stages use a valid/ready handshake.
//
//   Optional feature: define SHIFT_EXEC_PERF_EN to add the perf_ops and
//   perf_stall event counters.
//
// Ports
//   clk, arst                 clock (rising edge), async active-high reset
//   in_valid / in_ready       issue handshake
//   in_rs1                    value to shift
//   in_rs2                    register shift source, only [4:0] used
//   in_imm_shamt, in_is_imm   immediate shift amount and its select
//   in_funct3, in_funct7_b5   op decode (funct3, instruction bit 30)
//   in_rd                     destination tag
//   out_valid / out_ready     result handshake
//   out_result, out_rd        shift result and its tag
//   out_illegal               encoding was not a legal shift (result is 0)
//   perf_ops, perf_stall      (SHIFT_EXEC_PERF_EN only) completed ops and
//                             stalled request cycles, wrap modulo 2^32
module shift_exec_stage #(
   parameter int unsigned DPW  = 32,
   parameter int unsigned TAGW = 5
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DPW-1:0]  in_rs1,
   input  logic [DPW-1:0]  in_rs2,
   input  logic [4:0]      in_imm_shamt,
   input  logic            in_is_imm,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_b5,
   input  logic [TAGW-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DPW-1:0]  out_result,
   output logic [TAGW-1:0] out_rd,
   output logic            out_illegal
`ifdef SHIFT_EXEC_PERF_EN
   ,
   output logic [31:0]     perf_ops,
   output logic [31:0]     perf_stall
`endif
);

   // Stage 1: decoded operands
   logic            r_s1_valid;
   logic [DPW-1:0]  r_s1_opnd;
   logic [4:0]      r_s1_shamt;
   logic            r_s1_is_left;
   logic            r_s1_msb_ext;
   logic            r_s1_illegal;
   logic [TAGW-1:0] r_s1_rd;

   // Stage 2: result
   logic            r_out_valid;
   logic [DPW-1:0]  r_out_result;
   logic [TAGW-1:0] r_out_rd;
   logic            r_out_illegal;

   logic            w_s1_adv;
   logic            w_in_fire;
   logic            w_s2_load;
   logic            w_is_sll;
   logic            w_is_srl;
   logic            w_is_sra;
   logic [4:0]      w_shamt;
   logic [DPW-1:0]  w_rs1_rev;
   logic [2*DPW-1:0] w_ext;
   logic [DPW-1:0]  w_shr;
   logic [DPW-1:0]  w_shift_res;
   logic            w_unused_rs2_hi;

   assign w_unused_rs2_hi = ^in_rs2[DPW-1:5];

   // Handshake
   assign w_s1_adv  = !r_out_valid || out_ready;
   assign in_ready  = !arst && (!r_s1_valid || w_s1_adv);
   assign w_in_fire = in_valid && in_ready;
   assign w_s2_load = r_s1_valid && w_s1_adv;

   // Decode
   assign w_is_sll = (in_funct3 == 3'b001) && !in_funct7_b5;
   assign w_is_srl = (in_funct3 == 3'b101) && !in_funct7_b5;
   assign w_is_sra = (in_funct3 == 3'b101) &&  in_funct7_b5;
   assign w_shamt  = in_is_imm ? in_imm_shamt : in_rs2[4:0];

   always_comb begin
      w_rs1_rev = '0;
      for (int i = 0; i < DPW; i++) begin
         w_rs1_rev[i] = in_rs1[DPW-1-i];
      end
   end

   // Barrel shifter: always shifts right with a fill bit. Left shifts arrive
   // bit-reversed, so reversing the right-shifted value yields the left shift.
   assign w_ext = {{DPW{r_s1_msb_ext}}, r_s1_opnd} >> r_s1_shamt;
   assign w_shr = w_ext[DPW-1:0];

   always_comb begin
      w_shift_res = w_shr;
      if (r_s1_is_left) begin
         for (int i = 0; i < DPW; i++) begin
            w_shift_res[i] = w_shr[DPW-1-i];
         end
      end
      if (r_s1_illegal) begin
         w_shift_res = '0;
      end
   end

   // Stage 1 register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s1_valid   <= 1'b0;
         r_s1_opnd    <= '0;
         r_s1_shamt   <= '0;
         r_s1_is_left <= 1'b0;
         r_s1_msb_ext <= 1'b0;
         r_s1_illegal <= 1'b0;
         r_s1_rd      <= '0;
      end else if (w_in_fire) begin
         r_s1_valid   <= 1'b1;
         r_s1_opnd    <= w_is_sll ? w_rs1_rev : in_rs1;
         r_s1_shamt   <= w_shamt;
         r_s1_is_left <= w_is_sll;
         r_s1_msb_ext <= w_is_sra && in_rs1[DPW-1];
         r_s1_illegal <= !(w_is_sll || w_is_srl || w_is_sra);
         r_s1_rd      <= in_rd;
      end else if (w_s2_load) begin
         r_s1_valid   <= 1'b0;
      end
   end

   // Stage 2 register; holds while out_valid && !out_ready
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= '0;
         r_out_rd      <= '0;
         r_out_illegal <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid   <= 1'b1;
         r_out_result  <= w_shift_res;
         r_out_rd      <= r_s1_rd;
         r_out_illegal <= r_s1_illegal;
      end else if (out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_rd      = r_out_rd;
   assign out_illegal = r_out_illegal;

`ifdef SHIFT_EXEC_PERF_EN
   logic [31:0] r_perf_ops;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_perf_ops   <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_perf_ops <= r_perf_ops + 32'd1;
         end
         if (in_valid && !in_ready) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_ops   = r_perf_ops;
   assign perf_stall = r_perf_stall;
`else
   // Event counters compiled out.
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

   logic        clk = 1'b0;
   logic        arst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_imm_shamt;
   logic        in_is_imm;
   logic [2:0]  in_funct3;
   logic        in_funct7_b5;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;
`ifdef SHIFT_EXEC_PERF_EN
   logic [31:0] perf_ops;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   shift_exec_stage #(.DPW(32), .TAGW(5)) dut (
      .clk          (clk),
      .arst         (arst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_imm_shamt (in_imm_shamt),
      .in_is_imm    (in_is_imm),
      .in_funct3    (in_funct3),
      .in_funct7_b5 (in_funct7_b5),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .out_illegal  (out_illegal)
`ifdef SHIFT_EXEC_PERF_EN
      ,
      .perf_ops     (perf_ops),
      .perf_stall   (perf_stall)
`endif
   );

   int          checks   = 0;
   int          failures = 0;
   logic [37:0] exp_q[$];     // {result, rd, illegal}
   bit          rand_ready = 1'b0;
   logic        held_valid = 1'b0;
   logic [37:0] held_val;
   logic [37:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: plain RV32I shift semantics
   function automatic logic [37:0] model(input logic [31:0] rs1, input logic [4:0] sh,
                                         input logic [2:0] f3, input logic b5,
                                         input logic [4:0] rd);
      logic [31:0] r;
      logic        ill;
      ill = 1'b0;
      if (f3 == 3'b001 && !b5)      r = rs1 << sh;
      else if (f3 == 3'b101 && !b5) r = rs1 >> sh;
      else if (f3 == 3'b101 && b5)  r = $unsigned($signed(rs1) >>> sh);
      else begin
         r   = 32'd0;
         ill = 1'b1;
      end
      return {r, rd, ill};
   endfunction

   task automatic drive(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm,
                        input logic is_imm, input logic [2:0] f3, input logic b5,
                        input logic [4:0] rd, output logic [37:0] e);
      in_valid     = 1'b1;
      in_rs1       = rs1;
      in_rs2       = rs2;
      in_imm_shamt = imm;
      in_is_imm    = is_imm;
      in_funct3    = f3;
      in_funct7_b5 = b5;
      in_rd        = rd;
      e = model(rs1, is_imm ? imm : rs2[4:0], f3, b5, rd);
   endtask

   task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm,
                        input logic is_imm, input logic [2:0] f3, input logic b5,
                        input logic [4:0] rd);
      logic [37:0] e;
      int n = 0;
      @(negedge clk);
      drive(rs1, rs2, imm, is_imm, f3, b5, rd, e);
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      else exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid     = 1'b0;
         in_rs1       = $urandom;
         in_rs2       = $urandom;
         in_funct3    = 3'($urandom);
         in_funct7_b5 = 1'($urandom);
         in_rd        = 5'($urandom);
      end
   endtask

   task automatic issue_rand();
      int r;
      logic [2:0] f3;
      r  = $urandom_range(0, 9);
      f3 = (r < 4) ? 3'b001 : (r < 8) ? 3'b101 : 3'($urandom_range(0, 7));
      issue($urandom, $urandom, 5'($urandom), 1'($urandom), f3, 1'($urandom), 5'($urandom));
   endtask

   // Random back-pressure
   initial forever begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: pops the scoreboard on each completed transfer, checks hold stability
   initial forever begin
      @(negedge clk);
      #2;
      if (arst) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", {out_result, out_rd, out_illegal}, held_val);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", out_valid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("result", out_result, mon_e[37:6]);
               chk("rd", out_rd, mon_e[5:1]);
               chk("illegal", out_illegal, mon_e[0]);
            end
         end
         held_valid = out_valid && !out_ready;
         held_val   = {out_result, out_rd, out_illegal};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [37:0] e;
      int n;
      arst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_rs1 = '0; in_rs2 = '0; in_imm_shamt = '0; in_is_imm = 1'b0;
      in_funct3 = '0; in_funct7_b5 = 1'b0; in_rd = '0;
      repeat (2) @(negedge clk);
      arst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_illegal", out_illegal, 0);
      chk("rst_in_ready", in_ready, 1);

      // SLLI 1 << 31, latency 2
      issue(32'h0000_0001, 32'h0, 5'd31, 1'b1, 3'b001, 1'b0, 5'd7);
      @(negedge clk); in_valid = 1'b0;
      #1 chk("lat1_out_valid", out_valid, 0);
      @(negedge clk);
      #1 chk("lat2_out_valid", out_valid, 1);
      chk("slli_result", out_result, 32'h8000_0000);
      chk("slli_rd", out_rd, 7);
      idle(2);

      // SRA / SRL / shamt 0, back-to-back
      issue(32'h8000_00F0, 32'd4, 5'd0, 1'b0, 3'b101, 1'b1, 5'd1);
      issue(32'h8000_00F0, 32'd4, 5'd0, 1'b0, 3'b101, 1'b0, 5'd2);
      issue(32'h8000_00F0, 32'd4, 5'd0, 1'b1, 3'b101, 1'b1, 5'd3);
      issue(32'h8000_00F0, 32'd4, 5'd0, 1'b1, 3'b101, 1'b0, 5'd4);
      issue(32'h8000_00F0, 32'd4, 5'd0, 1'b1, 3'b001, 1'b0, 5'd5);
      // Illegal encodings
      issue(32'hDEAD_BEEF, 32'd3, 5'd0, 1'b0, 3'b001, 1'b1, 5'd9);
      issue(32'hDEAD_BEEF, 32'd3, 5'd0, 1'b0, 3'b000, 1'b0, 5'd10);
      idle(4);
      chk("directed_drained", exp_q.size(), 0);

      // Back-pressure: 4 ops with out_ready low
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h1234_5678, 32'd8, 5'd0, 1'b0, 3'b001, 1'b0, 5'd11, e);
      #1 chk("bp_rdy0", in_ready, 1);
      exp_q.push_back(e);
      @(negedge clk);
      drive(32'h8765_4321, 32'd0, 5'd12, 1'b1, 3'b101, 1'b1, 5'd12, e);
      #1 chk("bp_rdy1", in_ready, 1);
      exp_q.push_back(e);
      @(negedge clk);
      drive(32'hF0F0_0F0F, 32'd1, 5'd0, 1'b0, 3'b101, 1'b0, 5'd13, e);
      #1 chk("bp_rdy2", in_ready, 0);
      repeat (3) begin
         @(negedge clk);
         #1 chk("bp_full_rdy", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", in_ready, 1);
      exp_q.push_back(e);
      issue(32'hCAFE_F00D, 32'd31, 5'd0, 1'b0, 3'b101, 1'b1, 5'd14);
      idle(5);
      chk("bp_drained", exp_q.size(), 0);

      // Reset with both stages full
      @(negedge clk);
      out_ready = 1'b0;
      issue(32'h0000_00FF, 32'd1, 5'd0, 1'b0, 3'b001, 1'b0, 5'd20);
      issue(32'h0000_00FF, 32'd2, 5'd0, 1'b0, 3'b001, 1'b0, 5'd21);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("pre_rst_full", out_valid, 1);
      @(negedge clk);
      arst = 1'b1;
      #1 chk("midrst_out_valid", out_valid, 0);
      exp_q.delete();
      @(negedge clk);
      arst = 1'b0;
      out_ready = 1'b1;
      idle(5);
      chk("post_rst_valid", out_valid, 0);

      // Randomized traffic with random back-pressure
      rand_ready = 1'b1;
      repeat (300) begin
         issue_rand();
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rand_drained", exp_q.size(), 0);

`ifdef SHIFT_EXEC_PERF_EN
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      #1;
      chk("perf_ops_rst", perf_ops, 0);
      chk("perf_stall_rst", perf_stall, 0);
      repeat (10) issue($urandom, $urandom, 5'($urandom), 1'b1, 3'b101, 1'b0, 5'($urandom));
      idle(4);
      chk("perf_ops_10", perf_ops, 10);
      chk("perf_stall_0", perf_stall, 0);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      issue(32'h1, 32'h0, 5'd1, 1'b1, 3'b001, 1'b0, 5'd1);
      issue(32'h2, 32'h0, 5'd1, 1'b1, 3'b001, 1'b0, 5'd2);
      repeat (3) begin
         @(negedge clk);
         drive(32'h3, 32'h0, 5'd1, 1'b1, 3'b001, 1'b0, 5'd3, e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("perf_stall_3", perf_stall, 3);
      chk("perf_ops_held", perf_ops, 10);
      @(negedge clk);
      out_ready = 1'b1;
      idle(4);
      chk("perf_ops_12", perf_ops, 12);
      @(negedge clk);
      arst = 1'b1;
      #1;
      chk("perf_ops_arst", perf_ops, 0);
      chk("perf_stall_arst", perf_stall, 0);
      exp_q.delete();
      @(negedge clk);
      arst = 1'b0;
      idle(2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-stage wrapper that feeds the combinational barrel shifter (`shifter`) and captures its result.
- Decodes RV32I shift ops: SLL/SRL/SRA/SLLI/SRLI/SRAI.
- Bit-reverses the operand for left shifts, drives fill bit and shift amount, registers the result with a destination tag.
- Two-stage valid/ready pipeline between the issue logic and the writeback arbiter.

Parameters:
- DPW, rv32i_pkg::DPW (32), datapath width; must be 32.
- TAGW, 5, width of destination register tag.

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  asynchronous active-high reset.
- in_valid  input  1  issue request valid.
- in_ready  output  1  stage can accept the request this cycle.
- in_rs1  input  DPW  value to shift.
- in_rs2  input  DPW  register shift source; bits [4:0] used.
- in_imm_shamt  input  5  immediate shift amount.
- in_is_imm  input  1  1 = use in_imm_shamt, 0 = use in_rs2[4:0].
- in_funct3  input  3  instruction funct3.
- in_funct7_b5  input  1  instruction bit 30.
- in_rd  input  TAGW  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  DPW  shift result.
- out_rd  output  TAGW  destination tag of result.
- out_illegal  output  1  encoding was not a legal shift.

Behaviour:
- Reset: arst high forces s1_valid=0 and out_valid=0 immediately. out_result=0, out_rd=0, out_illegal=0. in_ready=1 once arst is low.
- Stage 1 (operand register): captures rs1, shamt, op, rd on in_valid && in_ready.
- Stage 2 (output register): captures the shifter output of the stage-1 contents.
- Handshake:
  - s1_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s1_adv (combinational).
  - Stage 2 loads when s1_valid && s1_adv.
  - out_valid clears when out_ready is high and no new load occurs.
  - Stage-2 outputs are held stable while out_valid && !out_ready.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 per cycle with out_ready held high.
- Decode:
  - funct3=001 and b5=0 -> SLL.
  - funct3=101 and b5=0 -> SRL.
  - funct3=101 and b5=1 -> SRA.
  - Anything else -> illegal, including funct3=001 with b5=1.
- Left shift: the stage-1 operand is stored bit-reversed and is_left=1 is sent to the shifter. The shifter re-reverses the output.
- MSB_ext = SRA && rs1[31]. It is 0 for SLL and SRL.
- shamt is 5 bits; no wrap beyond 31. shamt=0 returns rs1 unchanged for every op.
- Illegal op: out_result=0 and out_illegal=1; the tag still passes through. No exception is raised here.
- Simultaneous accept and drain in the same cycle is allowed; no bubble is inserted.
- When the pipeline is full and out_ready=0: in_ready=0 and both stages hold.
- Reset mid-operation: all in-flight entries are discarded and no out_valid pulse is emitted.
- in_* values are ignored when in_valid=0.

Optional Feature:
- Macro: SHIFT_EXEC_PERF_EN.
- With the macro defined, add two output ports:
  - perf_ops (32 bits): counts out_valid && out_ready.
  - perf_stall (32 bits): counts cycles with in_valid && !in_ready.
  - Both reset to 0, wrap modulo 2^32, and are updated in the same cycle as the event.
- Without the macro: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- SLLI: rs1=0x0000_0001, imm=31, funct3=001, b5=0, out_ready=1 -> result 0x8000_0000 two cycles after accept; out_illegal=0; out_rd matches.
- SRA vs SRL: rs1=0x8000_00F0, rs2=4.
  - SRA -> 0xF800_000F.
  - SRL -> 0x0800_000F.
  - shamt=0 -> 0x8000_00F0.
- Back-pressure: issue 4 back-to-back ops with out_ready=0.
  - in_ready drops after 2 accepts.
  - Outputs stay stable.
  - Releasing out_ready drains all 4 in order with no loss or duplication.
- Illegal: funct3=001 with b5=1, and funct3=000 -> result 0x0000_0000, out_illegal=1, tag passed through.
- Reset mid-flight: assert arst while both stages are valid -> out_valid=0 in the same cycle; no stale result appears after release.
- With SHIFT_EXEC_PERF_EN:
  - 10 completed ops -> perf_ops=10.
  - 3 stalled request cycles -> perf_stall=3.
  - arst -> both counters 0.
